// File: rtl/ex_mem_buffer.sv
// rtl/ex_mem_buffer.sv - EX/MEM pipeline register as a 2-entry skid buffer
// Optional flush port and behaviour enabled by defining EXMEM_FLUSH_EN.
module ex_mem_buffer #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
`ifdef EXMEM_FLUSH_EN
    input  logic         flush,
`endif
    input  logic [N-1:0] alu_result_i,
    input  logic         zero_i,
    input  logic [4:0]   rd_i,
    input  logic         mem_read_i,
    input  logic         mem_write_i,
    input  logic         reg_write_i,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] result_o,
    output logic         zero_o,
    output logic [4:0]   rd_o,
    output logic         mem_read_o,
    output logic         mem_write_o,
    output logic         reg_write_o,
    output logic         out_valid,
    input  logic         out_ready
);

    localparam int W = N + 9;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t         state;
    logic [W-1:0]   main_q;
    logic [W-1:0]   skid_q;
    logic [W-1:0]   entry_in;
    logic           push;
    logic           pop;
    logic           flush_req;

`ifdef EXMEM_FLUSH_EN
    assign flush_req = flush;
`else
    assign flush_req = 1'b0;
`endif

    // Writes to XZR are dropped at capture so the head never carries them.
    assign entry_in = {alu_result_i, zero_i, rd_i, mem_read_i, mem_write_i,
                       reg_write_i && (rd_i != 5'd31)};

    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign {result_o, zero_o, rd_o, mem_read_o, mem_write_o, reg_write_o} = main_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else if (flush_req) begin
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        main_q <= entry_in;
                        state  <= ONE;
                    end
                end
                ONE: begin
                    if (push && !pop) begin
                        skid_q <= entry_in;
                        state  <= FULL;
                    end else if (push && pop) begin
                        main_q <= entry_in;
                    end else if (pop) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        main_q <= skid_q;
                        state  <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_mem_buffer.sv
// tb/tb_ex_mem_buffer.sv - table-driven and scoreboard bench for ex_mem_buffer
module tb_ex_mem_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] alu_result_i;
    logic        zero_i;
    logic [4:0]  rd_i;
    logic        mem_read_i, mem_write_i, reg_write_i;
    logic        in_valid, in_ready;
    logic [63:0] result_o;
    logic        zero_o;
    logic [4:0]  rd_o;
    logic        mem_read_o, mem_write_o, reg_write_o;
    logic        out_valid, out_ready;
`ifdef EXMEM_FLUSH_EN
    logic        flush;
`endif

    int checks = 0;
    int failures = 0;
    bit armed = 1'b0;
    logic [72:0] sb_q[$];

    always #5 clk = ~clk;

    ex_mem_buffer #(.N(64)) dut (
        .clk(clk),
        .reset(reset),
`ifdef EXMEM_FLUSH_EN
        .flush(flush),
`endif
        .alu_result_i(alu_result_i),
        .zero_i(zero_i),
        .rd_i(rd_i),
        .mem_read_i(mem_read_i),
        .mem_write_i(mem_write_i),
        .reg_write_i(reg_write_i),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .result_o(result_o),
        .zero_o(zero_o),
        .rd_o(rd_o),
        .mem_read_o(mem_read_o),
        .mem_write_o(mem_write_o),
        .reg_write_o(reg_write_o),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    task automatic check(input string name, input logic [72:0] act, input logic [72:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: the queue is the reference occupancy and content of the buffer.
    always @(negedge clk) begin
        logic clear;
        clear = reset;
`ifdef EXMEM_FLUSH_EN
        clear = clear || flush;
`endif
        if (armed) begin
            check("sb_out_valid", 73'(out_valid), 73'(sb_q.size() != 0));
            check("sb_in_ready", 73'(in_ready), 73'(sb_q.size() < 2));
            if (sb_q.size() != 0)
                check("sb_head", {result_o, zero_o, rd_o, mem_read_o, mem_write_o, reg_write_o}, sb_q[0]);
            if (clear) begin
                sb_q.delete();
            end else begin
                if (out_valid && out_ready && sb_q.size() != 0)
                    void'(sb_q.pop_front());
                if (in_valid && sb_q.size() < 2 + ((out_valid && out_ready) ? 1 : 0) && in_ready)
                    sb_q.push_back({alu_result_i, zero_i, rd_i, mem_read_i, mem_write_i,
                                    reg_write_i && (rd_i != 5'd31)});
            end
        end
    end

    typedef struct {
        logic        v;
        logic [63:0] res;
        logic        z;
        logic [4:0]  rd;
        logic        mr, mw, rw;
        logic        ordy;
        logic        e_ov, e_ir;
        logic [63:0] e_res;
        logic        e_z;
        logic [4:0]  e_rd;
        logic        e_rw;
    } vec_t;

    vec_t vecs[11];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [63:0] res, input logic z,
                         input logic [4:0] rd, input logic mr, input logic mw,
                         input logic rw, input logic ordy);
        in_valid = v; alu_result_i = res; zero_i = z; rd_i = rd;
        mem_read_i = mr; mem_write_i = mw; reg_write_i = rw; out_ready = ordy;
    endtask

    initial begin
        vecs[0]  = '{1, 64'h1, 0, 5'd5, 0, 0, 1, 1,  1, 1, 64'h1, 0, 5'd5, 1};
        vecs[1]  = '{0, 64'h0, 0, 5'd0, 0, 0, 0, 1,  0, 1, 64'h1, 0, 5'd5, 1};
        vecs[2]  = '{1, 64'h0, 1, 5'd31, 0, 1, 1, 0, 1, 1, 64'h0, 1, 5'd31, 0};
        vecs[3]  = '{1, 64'h2, 0, 5'd3, 1, 0, 1, 1,  1, 1, 64'h2, 0, 5'd3, 1};
        vecs[4]  = '{1, 64'h3, 0, 5'd4, 0, 0, 1, 1,  1, 1, 64'h3, 0, 5'd4, 1};
        vecs[5]  = '{0, 64'h0, 0, 5'd0, 0, 0, 0, 1,  0, 1, 64'h3, 0, 5'd4, 1};
        vecs[6]  = '{1, 64'hFFFFFFFFFFFFFFFF, 0, 5'd7, 0, 0, 1, 0, 1, 1, 64'hFFFFFFFFFFFFFFFF, 0, 5'd7, 1};
        vecs[7]  = '{1, 64'h8000000000000000, 0, 5'd8, 0, 0, 1, 0, 1, 0, 64'hFFFFFFFFFFFFFFFF, 0, 5'd7, 1};
        vecs[8]  = '{1, 64'h55, 1, 5'd9, 1, 1, 1, 0, 1, 0, 64'hFFFFFFFFFFFFFFFF, 0, 5'd7, 1};
        vecs[9]  = '{0, 64'h0, 0, 5'd0, 0, 0, 0, 1,  1, 1, 64'h8000000000000000, 0, 5'd8, 1};
        vecs[10] = '{0, 64'h0, 0, 5'd0, 0, 0, 0, 1,  0, 1, 64'h8000000000000000, 0, 5'd8, 1};

        reset = 1'b1;
`ifdef EXMEM_FLUSH_EN
        flush = 1'b0;
`endif
        drive(0, 64'h0, 0, 5'd0, 0, 0, 0, 0);
        step();
        step();
        reset = 1'b0;
        armed = 1'b1;
        check("rst_out_valid", 73'(out_valid), 73'(0));
        check("rst_in_ready", 73'(in_ready), 73'(1));
        check("rst_payload", {result_o, zero_o, rd_o, mem_read_o, mem_write_o, reg_write_o}, 73'(0));

        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].v, vecs[i].res, vecs[i].z, vecs[i].rd, vecs[i].mr, vecs[i].mw,
                  vecs[i].rw, vecs[i].ordy);
            step();
            check($sformatf("vec%0d_out_valid", i), 73'(out_valid), 73'(vecs[i].e_ov));
            check($sformatf("vec%0d_in_ready", i), 73'(in_ready), 73'(vecs[i].e_ir));
            check($sformatf("vec%0d_result", i), 73'(result_o), 73'(vecs[i].e_res));
            check($sformatf("vec%0d_zero", i), 73'(zero_o), 73'(vecs[i].e_z));
            check($sformatf("vec%0d_rd", i), 73'(rd_o), 73'(vecs[i].e_rd));
            check($sformatf("vec%0d_reg_write", i), 73'(reg_write_o), 73'(vecs[i].e_rw));
        end

        // Reset while FULL discards both entries and clears the payload.
        drive(1, 64'hA, 0, 5'd10, 0, 0, 1, 0);
        step();
        drive(1, 64'hB, 0, 5'd11, 0, 0, 1, 0);
        step();
        drive(0, 64'h0, 0, 5'd0, 0, 0, 0, 0);
        check("full_in_ready", 73'(in_ready), 73'(0));
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("full_rst_out_valid", 73'(out_valid), 73'(0));
        check("full_rst_result", 73'(result_o), 73'(0));
        check("full_rst_in_ready", 73'(in_ready), 73'(1));
        check("full_rst_rd", 73'(rd_o), 73'(0));

`ifdef EXMEM_FLUSH_EN
        drive(1, 64'hC, 0, 5'd12, 0, 0, 1, 0);
        step();
        drive(1, 64'hD, 0, 5'd13, 0, 0, 1, 0);
        step();
        drive(1, 64'hE, 0, 5'd14, 0, 0, 1, 1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(0, 64'h0, 0, 5'd0, 0, 0, 0, 0);
        check("flush_out_valid", 73'(out_valid), 73'(0));
        check("flush_result", 73'(result_o), 73'(64'hC));
        check("flush_in_ready", 73'(in_ready), 73'(1));
        step();
        check("flush_stays_empty", 73'(out_valid), 73'(0));
`endif

        step();
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
